// File: rtl/debounce_pkg.sv
// Shared state encoding, board timing defaults and a parameter bound helper
// for the push-button debouncer.
package debounce_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // 100 MHz board build: 5 ms qualification, 500 ms first repeat, 100 ms period
  localparam int PRESS_CYCLES_HW   = 500_000;
  localparam int RELEASE_CYCLES_HW = 500_000;
  localparam int REPEAT_DELAY_HW   = 50_000_000;
  localparam int REPEAT_PERIOD_HW  = 10_000_000;

  // True when v is representable in an unsigned counter of width w
  function automatic bit fits(input int v, input int w);
    return longint'(v) < (longint'(1) << w);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, press/release qualification FSM,
// registered level and one-cycle press/release/repeat pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W          = 20,
  parameter int PRESS_CYCLES   = 5,
  parameter int RELEASE_CYCLES = 5,
  parameter int REPEAT_EN      = 0,
  parameter int RPT_W          = 27,
  parameter int REPEAT_DELAY   = 20,
  parameter int REPEAT_PERIOD  = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic press_set      // press about to be registered this edge
);

  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST  = RPT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync;
  logic             btn_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] qcnt;
  logic [RPT_W-1:0] rcnt;
  logic             rpt_armed;  // first repeat already issued in this hold
  logic             rpt_hit;

  assign btn_s     = sync[1];
  assign press_set = (state == ST_PRESS_WAIT) && btn_s && (qcnt == PRESS_LAST);
  assign rpt_hit   = rpt_armed ? (rcnt == PERIOD_LAST) : (rcnt == DELAY_LAST);

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b00;
    else          sync <= {sync[0], btn};
  end

  // Qualification FSM with counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      qcnt          <= '0;
      rcnt          <= '0;
      rpt_armed     <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_s) begin
            qcnt  <= CNT_W'(1);
            state <= ST_PRESS_WAIT;
          end
        end
        ST_PRESS_WAIT: begin
          if (!btn_s) begin
            qcnt  <= '0;
            state <= ST_IDLE;
          end else if (press_set) begin
            state     <= ST_HELD;
            level     <= 1'b1;
            press     <= 1'b1;
            rcnt      <= '0;
            rpt_armed <= 1'b0;
          end else begin
            qcnt <= qcnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          // Leaving HELD wins over a repeat due on the same edge
          if (!btn_s) begin
            qcnt  <= CNT_W'(1);
            state <= ST_RELEASE_WAIT;
          end else if (REPEAT_EN != 0) begin
            if (rpt_hit) begin
              repeat_pulse <= 1'b1;
              rcnt         <= '0;
              rpt_armed    <= 1'b1;
            end else begin
              rcnt <= rcnt + RPT_W'(1);
            end
          end
        end
        default: begin  // ST_RELEASE_WAIT; rcnt frozen so glitches keep repeat phase
          if (btn_s) begin
            state <= ST_HELD;
          end else if (qcnt == RELEASE_LAST) begin
            state         <= ST_IDLE;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            qcnt <= qcnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer. release/repeat are SystemVerilog keywords,
// so those outputs carry a _pulse suffix.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH           = 5,
  parameter int CNT_W          = 20,
  parameter int PRESS_CYCLES   = 5,
  parameter int RELEASE_CYCLES = 5,
  parameter int REPEAT_EN      = 0,
  parameter int RPT_W          = 27,
  parameter int REPEAT_DELAY   = 20,
  parameter int REPEAT_PERIOD  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  // Bounds that keep every counter compare reachable (no wrap)
  if (PRESS_CYCLES < 2 || !fits(PRESS_CYCLES, CNT_W))
    $error("PRESS_CYCLES out of range for CNT_W");
  if (RELEASE_CYCLES < 2 || !fits(RELEASE_CYCLES, CNT_W))
    $error("RELEASE_CYCLES out of range for CNT_W");
  if (REPEAT_DELAY < 1 || !fits(REPEAT_DELAY, RPT_W))
    $error("REPEAT_DELAY out of range for RPT_W");
  if (REPEAT_PERIOD < 1 || !fits(REPEAT_PERIOD, RPT_W))
    $error("REPEAT_PERIOD out of range for RPT_W");

  logic [N_CH-1:0] press_set;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W(CNT_W), .PRESS_CYCLES(PRESS_CYCLES), .RELEASE_CYCLES(RELEASE_CYCLES),
      .REPEAT_EN(REPEAT_EN), .RPT_W(RPT_W),
      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk), .reset_n(reset_n), .btn(btn[i]),
      .level(level[i]), .press(press[i]),
      .release_pulse(release_pulse[i]), .repeat_pulse(repeat_pulse[i]),
      .press_set(press_set[i])
    );
  end

  // OR of the next-cycle press terms so any_press lines up with press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_press <= 1'b0;
    else          any_press <= |press_set;
  end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- Parametrised N-channel successor to the single-button debouncer. One instance cleans every push-button on the board.
- Each channel has:
  - a 2-flop input synchroniser;
  - separate press and release qualification times;
  - a debounced level output, one-cycle press and release pulses, and an optional hold-to-repeat pulse.
- Sits between the raw BTN pins and the input decoder / game-control FSMs.

Parameters:
- N_CH, 5, number of independent button channels.
- CNT_W, 20, width of the per-channel qualification counter.
- PRESS_CYCLES, 5, consecutive synchronised-high samples that confirm a press. Must be ≥2 and <2^CNT_W.
- RELEASE_CYCLES, 5, consecutive synchronised-low samples that confirm a release. Must be ≥2 and <2^CNT_W.
- REPEAT_EN, 0, 1 enables the hold-to-repeat pulse output.
- RPT_W, 27, width of the per-channel repeat counter.
- REPEAT_DELAY, 20, cycles in HELD before the first repeat pulse. Must be ≥1 and <2^RPT_W.
- REPEAT_PERIOD, 8, cycles between subsequent repeat pulses. Must be ≥1 and <2^RPT_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- btn  in  N_CH  raw, asynchronous, bouncing button inputs.
- level  out  N_CH  debounced button state, registered.
- press  out  N_CH  one-cycle pulse on a confirmed press.
- release  out  N_CH  one-cycle pulse on a confirmed release.
- repeat  out  N_CH  one-cycle auto-repeat pulse while held; constant 0 when REPEAT_EN=0.
- any_press  out  1  registered OR of press, aligned with press.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all outputs 0;
  - synchroniser flops 0;
  - every channel in IDLE;
  - both counters 0.
- Reset mid-debounce discards the qualification in progress. A button still held when reset deasserts is qualified as a fresh press.
- Synchroniser: btn[i] passes through two flops to btn_s[i]. A raw change sampled at edge e is first seen by the FSM at edge e+2.
- Per-channel FSM, evaluated on btn_s; qcnt is the qualification counter, rcnt the repeat counter:
  - IDLE: if btn_s=1, qcnt<=1 and go to PRESS_WAIT. Otherwise stay.
  - PRESS_WAIT:
    - btn_s=0: go to IDLE, qcnt<=0 (any bounce restarts qualification);
    - btn_s=1 and qcnt==PRESS_CYCLES-1: go to HELD, level<=1, press<=1, rcnt<=0;
    - otherwise qcnt<=qcnt+1.
  - HELD:
    - btn_s=0: qcnt<=1 and go to RELEASE_WAIT.
    - Repeat (REPEAT_EN=1 only), counted while in HELD:
      - first pulse when rcnt reaches REPEAT_DELAY-1, then rcnt<=0;
      - afterwards, a pulse every REPEAT_PERIOD cycles.
  - RELEASE_WAIT:
    - btn_s=1: return to HELD. level stays 1, no pulse; rcnt holds its value (a glitch does not restart repeat timing).
    - btn_s=0 and qcnt==RELEASE_CYCLES-1: go to IDLE, level<=0, release<=1.
    - otherwise qcnt<=qcnt+1.
- Pulse timing:
  - press, release and repeat are registered and high for exactly one cycle. They default to 0 every cycle they are not set.
  - Latency: a raw rising edge sampled at edge 0 and then stable gives press and level high after edge PRESS_CYCLES+1. Release is symmetric with RELEASE_CYCLES.
  - repeat never coincides with press. Leaving HELD on a cycle where repeat would fire suppresses that pulse.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Counters never wrap, because the parameter bounds above keep every compare reachable. The implementation adds elaboration-time checks on these bounds.

Decomposition:
- Package debounce_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_HELD=2'd2, ST_RELEASE_WAIT=2'd3;
  - default timing constants for the 100 MHz board build: PRESS_CYCLES_HW=500_000, RELEASE_CYCLES_HW=500_000, REPEAT_DELAY_HW=50_000_000, REPEAT_PERIOD_HW=10_000_000.
- Sub-module debounce_channel holds one channel: synchroniser, FSM, qcnt and rcnt, with level/press/release/repeat outputs.
- The top level is a generate loop over N_CH plus the any_press register.

Test Plan:
1. Clean press, defaults (PRESS_CYCLES=5): btn[0] goes 0→1 before edge 0 and holds → level[0] and press[0] rise after edge 6; press[0] high exactly 1 cycle; any_press pulses in the same cycle.
2. Bounce: btn[1] high 3 cycles, low 1, high 4, low 1, then stable high → no press until 5 consecutive btn_s highs; exactly one press pulse.
3. Release with glitch: channel held, btn low 2 cycles, high 1, low stable → level stays 1 through the glitch; release pulse 1 cycle after 5 consecutive lows; no second press.
4. Repeat (REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=8): hold 50 cycles after press → repeat pulses 20, 28, 36 and 44 cycles after the press pulse; none after release is confirmed.
5. Simultaneous and reset: press btn[0] and btn[4] on the same edge → both press bits pulse in the same cycle. Assert reset_n=0 mid PRESS_WAIT with btn held → outputs 0 immediately; after deassert, press fires 7 edges later.
